// File: rtl/program_loader_if.sv
// program_loader_if: byte stream handshake between a source and the loader
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: turns a framed byte stream into 32-bit memory writes, holding the CPU in reset until loaded
module program_loader #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    program_loader_if.slave   in_if,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              hold_cpu,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [12:0]       DEPTH_C = 13'(DEPTH);

    state_t              state_q, state_d;
    logic [7:0]          hdr_lo_q, hdr_lo_d;
    logic [12:0]         count_q, count_d;
    logic [12:0]         word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_q, word_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic                mem_wren_q, mem_wren_d;
    logic                hold_cpu_q, hold_cpu_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;
    logic [12:0]         hdr_count;

    assign in_if.in_ready = (state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign hdr_count      = {in_if.in_data[4:0], hdr_lo_q};

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign hold_cpu    = hold_cpu_q;
    assign done        = done_q;
    assign error       = error_q;

    // Frame parser: header capture, word assembly (first byte lands in the low lane), write issue
    always_comb begin
        state_d       = state_q;
        hdr_lo_d      = hdr_lo_q;
        count_d       = count_q;
        word_idx_d    = word_idx_q;
        byte_idx_d    = byte_idx_q;
        word_d        = word_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        hold_cpu_d    = hold_cpu_q;
        done_d        = done_q;
        error_d       = error_q;
        case (state_q)
            HDR_LO: if (accept) begin
                hdr_lo_d = in_if.in_data;
                state_d  = HDR_HI;
            end
            HDR_HI: if (accept) begin
                count_d = hdr_count;
                error_d = (hdr_count == 13'd0) || (hdr_count > DEPTH_C);
                state_d = error_d ? ERR : DATA;
            end
            DATA: if (accept) begin
                word_d     = {in_if.in_data, word_q[23:8]};
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    mem_data_d    = {in_if.in_data, word_q};
                    mem_address_d = BASE_A + ADDR_W'(word_idx_q);
                    mem_wren_d    = 1'b1;
                    state_d       = WRITE;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 13'd1;
                if (word_idx_d == count_q) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    hold_cpu_d = 1'b0;
                end else begin
                    state_d = DATA;
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset discards any partial frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= HDR_LO;
            hdr_lo_q      <= '0;
            count_q       <= '0;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            word_q        <= '0;
            mem_address_q <= BASE_A;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            hold_cpu_q    <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_lo_q      <= hdr_lo_d;
            count_q       <= count_d;
            word_idx_q    <= word_idx_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            hold_cpu_q    <= hold_cpu_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frames against a byte-counting reference model, two base addresses
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    int         checks = 0;
    int         errors = 0;
    bit         tog = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int B = (g == 0) ? 0 : 4094;
        program_loader_if bus ();
        logic [11:0] addr;
        logic [31:0] data;
        logic        wren, hold, dn, er, rdy;
        logic [31:0] mem [4096];
        int          nwr;
        // reference model state: counts bytes of the frame, tracks outstanding write
        logic        m_wr, m_done, m_err;
        int          m_nb, m_cnt, m_widx;
        logic [7:0]  m_lo;
        logic [31:0] m_word, m_data;
        logic [11:0] m_addr;
        logic [12:0] hdrc;
        logic [1:0]  lane;

        assign bus.in_valid = in_valid;
        assign bus.in_data  = in_data;
        assign rdy          = bus.in_ready;
        assign hdrc         = {in_data[4:0], m_lo};
        assign lane         = 2'(m_nb - 2);

        program_loader #(.ADDR_W(12), .DEPTH(4096), .BASE_ADDR(B)) dut (
            .clock(clk), .reset(rst_n), .in_if(bus),
            .mem_address(addr), .mem_data(data), .mem_wren(wren),
            .hold_cpu(hold), .done(dn), .error(er)
        );

        // model: byte n of the frame is header (n<2) or lane (n-2)%4 of word (n-2)/4
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_wr <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
                m_nb <= 0; m_cnt <= 0; m_widx <= 0;
                m_lo <= 8'h00; m_word <= 32'h0; m_data <= 32'h0; m_addr <= 12'(B);
            end else if (m_wr) begin
                m_wr   <= 1'b0;
                m_widx <= m_widx + 1;
                if (m_widx + 1 == m_cnt) m_done <= 1'b1;
            end else if (in_valid && !m_done && !m_err) begin
                m_nb <= m_nb + 1;
                if (m_nb == 0) m_lo <= in_data;
                else if (m_nb == 1) begin
                    m_cnt <= int'(hdrc);
                    m_err <= (hdrc == 13'd0) || (hdrc > 13'd4096);
                end else begin
                    m_word[8*lane +: 8] <= in_data;
                    if (lane == 2'd3) begin
                        m_wr   <= 1'b1;
                        m_addr <= 12'(B + m_widx);
                        m_data <= {in_data, m_word[23:0]};
                    end
                end
            end
        end

        // compare every output every cycle; also capture writes into a memory image
        always @(negedge clk) begin
            check($sformatf("i%0d.in_ready", g), 32'(rdy), 32'(!m_wr && !m_done && !m_err));
            check($sformatf("i%0d.mem_wren", g), 32'(wren), 32'(m_wr));
            check($sformatf("i%0d.mem_address", g), 32'(addr), 32'(m_addr));
            check($sformatf("i%0d.mem_data", g), data, m_data);
            check($sformatf("i%0d.hold_cpu", g), 32'(hold), 32'(!m_done));
            check($sformatf("i%0d.done", g), 32'(dn), 32'(m_done));
            check($sformatf("i%0d.error", g), 32'(er), 32'(m_err));
            if (!rst_n) nwr <= 0;
            else if (wren) begin
                mem[addr] <= data;
                nwr <= nwr + 1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    // mode 0: always valid, 1: random bubbles, 2: valid toggles every cycle
    task automatic send_byte(input logic [7:0] b, input int mode);
        int  t = 0;
        bit  acc = 1'b0;
        while (!acc) begin
            in_data  = b;
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : tog;
            tog = ~tog;
            @(negedge clk);
            acc = in_valid && inst[0].rdy;
            @(posedge clk);
            #1;
            if (++t > 200) begin
                errors++;
                $display("FAIL send_byte timeout: byte %h never accepted", b);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int mode);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], mode);
    endtask

    task automatic send_hdr(input int c, input int mode);
        logic [12:0] cc;
        cc = 13'(c);
        send_byte(cc[7:0], mode);
        send_byte({3'($urandom), cc[12:8]}, mode);
    endtask

    initial begin
        logic [31:0] w [3];
        int          c;
        bit          ok;

        // reset values
        cycles(2);
        check("reset.in_ready", 32'(inst[0].rdy), 32'd1);
        check("reset.hold_cpu", 32'(inst[0].hold), 32'd1);
        check("reset.done", 32'(inst[0].dn), 32'd0);
        check("reset.addr1", 32'(inst[1].addr), 32'd4094);
        rst_n = 1'b1;

        // two-word frame
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'h12345678, 0);
        send_word(32'hDEADBEEF, 0);
        cycles(3);
        check("t1.mem0", inst[0].mem[0], 32'h12345678);
        check("t1.mem1", inst[0].mem[1], 32'hDEADBEEF);
        check("t1.nwr", 32'(inst[0].nwr), 32'd2);
        check("t1.done", 32'(inst[0].dn), 32'd1);
        check("t1.hold", 32'(inst[0].hold), 32'd0);

        // zero count header
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        in_valid = 1'b1; in_data = 8'h55;
        cycles(5);
        in_valid = 1'b0;
        check("t2.error", 32'(inst[0].er), 32'd1);
        check("t2.hold", 32'(inst[0].hold), 32'd1);
        check("t2.in_ready", 32'(inst[0].rdy), 32'd0);
        check("t2.nwr", 32'(inst[0].nwr), 32'd0);

        // count just above and at the depth limit
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h10, 0);
        cycles(1);
        check("t3.error4097", 32'(inst[0].er), 32'd1);
        do_reset();
        send_byte(8'h00, 0); send_byte(8'hF0, 0);
        check("t3.ok4096", 32'(inst[0].er), 32'd0);
        for (int i = 0; i < 4096; i++) send_word($urandom, 0);
        cycles(2);
        check("t3.done", 32'(inst[0].dn), 32'd1);
        check("t3.nwr", 32'(inst[1].nwr), 32'd4096);

        // single word with valid toggling
        do_reset();
        send_byte(8'h01, 2); send_byte(8'h00, 2);
        send_word(32'h04030201, 2);
        cycles(2);
        check("t4.mem0", inst[0].mem[0], 32'h04030201);
        check("t4.nwr", 32'(inst[0].nwr), 32'd1);

        // reset in the middle of the first word, then a full resend
        do_reset();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        rst_n = 1'b0;
        cycles(2);
        check("t5.in_ready", 32'(inst[0].rdy), 32'd1);
        check("t5.addr", 32'(inst[0].addr), 32'd0);
        check("t5.data", inst[0].data, 32'd0);
        check("t5.hold", 32'(inst[0].hold), 32'd1);
        rst_n = 1'b1;
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_word(32'hCAFEF00D, 1);
        send_word(32'h0BADC0DE, 1);
        cycles(2);
        check("t5.mem0", inst[0].mem[0], 32'hCAFEF00D);
        check("t5.mem1", inst[0].mem[1], 32'h0BADC0DE);
        check("t5.done", 32'(inst[0].dn), 32'd1);

        // three words at base 4094 wrap to address 0
        do_reset();
        send_hdr(3, 1);
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            send_word(w[i], 1);
        end
        cycles(2);
        check("t6.mem4094", inst[1].mem[4094], w[0]);
        check("t6.mem4095", inst[1].mem[4095], w[1]);
        check("t6.mem0", inst[1].mem[0], w[2]);
        check("t6.done", 32'(inst[1].dn), 32'd1);

        // random frames, occasionally with an illegal count
        for (int f = 0; f < 8; f++) begin
            do_reset();
            c = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) c = ($urandom_range(0, 1) == 0) ? 0 : 4097 + $urandom_range(0, 4000);
            ok = (c != 0) && (c <= 4096);
            send_hdr(c, 1);
            if (ok) for (int i = 0; i < c; i++) send_word($urandom, 1);
            cycles(3);
            check($sformatf("rand%0d.done", f), 32'(inst[0].dn), 32'(ok));
            check($sformatf("rand%0d.error", f), 32'(inst[0].er), 32'(!ok));
            check($sformatf("rand%0d.nwr", f), 32'(inst[1].nwr), ok ? 32'(c) : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
